// File: rtl/ps_width_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : ps_width_gearbox
// Description : Packet-preserving word-width gearbox. Converts IWORDS-word
//               input beats into OWORDS-word output beats through a small
//               word buffer. Packets never merge or split.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_width_gearbox #(
  parameter int WIDTH  = 8,
  parameter int IWORDS = 4,
  parameter int OWORDS = 3,
  localparam int IMW   = (IWORDS > 1) ? $clog2(IWORDS) : 1,
  localparam int OMW   = (OWORDS > 1) ? $clog2(OWORDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IWORDS*WIDTH-1:0]  i_dat,
  input  logic [IMW-1:0]           i_mty,
  input  logic                     i_val,
  input  logic                     i_eop,
  output logic                     i_rdy,
  output logic [OWORDS*WIDTH-1:0]  o_dat,
  output logic [OMW-1:0]           o_mty,
  output logic                     o_val,
  output logic                     o_eop,
  input  logic                     o_rdy
);

  localparam int c_B  = IWORDS + OWORDS;
  localparam int c_CW = $clog2(c_B + 1);
  localparam logic [c_CW-1:0] c_OW = c_CW'(OWORDS);

  // Buffer is kept as one packed vector: word 0 (the head) in the LS bits.
  logic [c_B*WIDTH-1:0] r_buf;
  logic [c_CW-1:0]      r_cnt;
  logic                 r_eop_pend;

  logic                 w_push;
  logic                 w_pop;
  int                   w_pop_n;
  int                   w_rem;
  int                   w_push_n;
  logic [c_B*WIDTH-1:0] w_shift;
  logic [c_B*WIDTH-1:0] w_ins;
  logic [c_B*WIDTH-1:0] w_msk;
  logic [c_B*WIDTH-1:0] w_buf_nxt;
  logic [c_CW-1:0]      w_cnt_nxt;

  // Handshake and output flags come only from registered state (plus reset).
  assign i_rdy  = !reset && !r_eop_pend && (r_cnt <= c_OW);
  assign o_val  = (r_cnt >= c_OW) || (r_eop_pend && (r_cnt != '0));
  assign o_eop  = r_eop_pend && (r_cnt <= c_OW);
  assign o_mty  = o_eop ? OMW'(c_OW - r_cnt) : '0;
  assign o_dat  = r_buf[OWORDS*WIDTH-1:0];
  assign w_push = i_val && i_rdy;
  assign w_pop  = o_val && o_rdy;

  // Pop from the head, then append the accepted beat after the remaining words.
  always_comb begin
    w_pop_n  = 0;
    w_push_n = 0;
    if (w_pop) begin
      w_pop_n = (int'(r_cnt) < OWORDS) ? int'(r_cnt) : OWORDS;
    end
    w_rem = int'(r_cnt) - w_pop_n;
    if (w_push) begin
      w_push_n = IWORDS - (i_eop ? int'(i_mty) : 0);
    end
    w_shift   = r_buf >> (w_pop_n * WIDTH);
    w_ins     = {{(OWORDS*WIDTH){1'b0}}, i_dat} << (w_rem * WIDTH);
    w_msk     = {{(OWORDS*WIDTH){1'b0}}, {(IWORDS*WIDTH){1'b1}}} << (w_rem * WIDTH);
    w_buf_nxt = w_push ? ((w_shift & ~w_msk) | w_ins) : w_shift;
    w_cnt_nxt = c_CW'(w_rem + w_push_n);
  end

  // Word count and end-of-packet tracking; reset discards buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_eop_pend <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_pop && o_eop) begin
        r_eop_pend <= 1'b0;
      end else if (w_push && i_eop) begin
        r_eop_pend <= 1'b1;
      end
    end
  end

  // Data words need no reset: the count alone decides which words are live.
  always_ff @(posedge clk) begin
    r_buf <= w_buf_nxt;
  end

endmodule
`default_nettype wire

// File: tb/tb_ps_width_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps_width_gearbox
// Description : Directed self-checking bench for ps_width_gearbox
//               (WIDTH=8, IWORDS=4, OWORDS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_width_gearbox;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_dat;
  logic [1:0]  i_mty;
  logic        i_val;
  logic        i_eop;
  logic        i_rdy;
  logic [23:0] o_dat;
  logic [1:0]  o_mty;
  logic        o_val;
  logic        o_eop;
  logic        o_rdy;

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit rx_done;

  ps_width_gearbox #(.WIDTH(8), .IWORDS(4), .OWORDS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .i_dat (i_dat),
    .i_mty (i_mty),
    .i_val (i_val),
    .i_eop (i_eop),
    .i_rdy (i_rdy),
    .o_dat (o_dat),
    .o_mty (o_mty),
    .o_val (o_val),
    .o_eop (o_eop),
    .o_rdy (o_rdy)
  );

  always #5 clk = ~clk;

  // Present a beat (caller is just after a rising edge) and wait for acceptance.
  task automatic send_beat(input logic [31:0] d, input logic eop, input logic [1:0] mty);
    bit ok;
    ok    = 1'b0;
    i_dat = d;
    i_eop = eop;
    i_mty = mty;
    i_val = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (i_rdy) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    i_val = 1'b0;
    i_eop = 1'b0;
    i_mty = 2'd0;
    check_cnt++;
    if (!ok) $display("FAIL send_timeout: beat %h not accepted, i_rdy=%b want 1", d, i_rdy);
    else pass_cnt++;
  endtask

  // Capture the next output beat that completes a handshake.
  task automatic recv_beat(output logic [23:0] d, output logic e, output logic [1:0] m, output bit ok);
    ok = 1'b0;
    d  = '0;
    e  = 1'b0;
    m  = '0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (o_val && o_rdy) begin
        d  = o_dat;
        e  = o_eop;
        m  = o_mty;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i_val = 1'b0;
    i_eop = 1'b0;
    i_mty = 2'd0;
    i_dat = '0;
    o_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_cnt++;
      if (o_val !== 1'b0 || o_eop !== 1'b0 || i_rdy !== 1'b0 || o_mty !== 2'd0)
        $display("FAIL reset_hold cyc%0d: got val=%b eop=%b rdy=%b mty=%0d, want 0 0 0 0",
                 c, o_val, o_eop, i_rdy, o_mty);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (i_rdy !== 1'b1 || o_val !== 1'b0)
      $display("FAIL reset_release: got i_rdy=%b o_val=%b, want 1 0", i_rdy, o_val);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [23:0] exp_d [3];
    logic [23:0] msk   [3];
    logic        exp_e [3];
    logic [1:0]  exp_m [3];
    exp_d[0] = 24'h030201; msk[0] = 24'hFFFFFF; exp_e[0] = 1'b0; exp_m[0] = 2'd0;
    exp_d[1] = 24'h060504; msk[1] = 24'hFFFFFF; exp_e[1] = 1'b0; exp_m[1] = 2'd0;
    exp_d[2] = 24'h000807; msk[2] = 24'h00FFFF; exp_e[2] = 1'b1; exp_m[2] = 2'd1;
    o_rdy = 1'b1;
    fork
      begin
        send_beat(32'h04030201, 1'b0, 2'd0);
        send_beat(32'h08070605, 1'b1, 2'd0);
      end
      begin
        logic [23:0] d; logic e; logic [1:0] m; bit ok;
        for (int k = 0; k < 3; k++) begin
          recv_beat(d, e, m, ok);
          check_cnt++;
          if (!ok || (d & msk[k]) !== exp_d[k] || e !== exp_e[k] || m !== exp_m[k])
            $display("FAIL basic_beat%0d: got ok=%b dat=%h eop=%b mty=%0d, want dat=%h eop=%b mty=%0d",
                     k, ok, d & msk[k], e, m, exp_d[k], exp_e[k], exp_m[k]);
          else pass_cnt++;
        end
      end
    join
  endtask

  task automatic test_short;
    o_rdy = 1'b0;
    i_dat = 32'h00000A09;
    i_eop = 1'b1;
    i_mty = 2'd2;
    i_val = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (i_rdy !== 1'b1) $display("FAIL short_ready: got i_rdy=%b, want 1", i_rdy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    i_val = 1'b0;
    i_eop = 1'b0;
    i_mty = 2'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_cnt++;
      if (o_val !== 1'b1 || o_eop !== 1'b1 || o_mty !== 2'd1 || o_dat[15:0] !== 16'h0A09 || i_rdy !== 1'b0)
        $display("FAIL short_out cyc%0d: got val=%b eop=%b mty=%0d dat=%h rdy=%b, want 1 1 1 0a09 0",
                 c, o_val, o_eop, o_mty, o_dat[15:0], i_rdy);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    o_rdy = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cnt++;
    if (o_val !== 1'b0 || i_rdy !== 1'b1)
      $display("FAIL short_drain: got o_val=%b i_rdy=%b, want 0 1", o_val, i_rdy);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall;
    o_rdy = 1'b0;
    send_beat(32'h0E0D0C0B, 1'b0, 2'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_cnt++;
      if (o_val !== 1'b1 || o_dat !== 24'h0D0C0B || o_eop !== 1'b0 || o_mty !== 2'd0 || i_rdy !== 1'b0)
        $display("FAIL stall_hold cyc%0d: got val=%b dat=%h eop=%b mty=%0d rdy=%b, want 1 0d0c0b 0 0 0",
                 c, o_val, o_dat, o_eop, o_mty, i_rdy);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    o_rdy = 1'b1;
    fork
      send_beat(32'h1211100F, 1'b1, 2'd0);
      begin
        logic [23:0] d; logic e; logic [1:0] m; bit ok;
        recv_beat(d, e, m, ok);
        check_cnt++;
        if (!ok || d !== 24'h0D0C0B || e !== 1'b0)
          $display("FAIL stall_beat0: got ok=%b dat=%h eop=%b, want 0d0c0b 0", ok, d, e);
        else pass_cnt++;
        recv_beat(d, e, m, ok);
        check_cnt++;
        if (!ok || d !== 24'h100F0E || e !== 1'b0)
          $display("FAIL stall_beat1: got ok=%b dat=%h eop=%b, want 100f0e 0", ok, d, e);
        else pass_cnt++;
        recv_beat(d, e, m, ok);
        check_cnt++;
        if (!ok || d[15:0] !== 16'h1211 || e !== 1'b1 || m !== 2'd1)
          $display("FAIL stall_beat2: got ok=%b dat=%h eop=%b mty=%0d, want 1211 1 1", ok, d[15:0], e, m);
        else pass_cnt++;
      end
    join
  endtask

  task automatic test_random;
    int lens [50];
    for (int p = 0; p < 50; p++) lens[p] = $urandom_range(1, 20);
    rx_done = 1'b0;
    fork
      begin : sender
        int b;
        b = 0;
        for (int p = 0; p < 50 && !rx_done; p++) begin
          for (int off = 0; off < lens[p] && !rx_done; off += 4) begin
            logic [31:0] d;
            int n;
            n = (lens[p] - off < 4) ? lens[p] - off : 4;
            d = '0;
            for (int j = 0; j < n; j++) d[j*8 +: 8] = 8'((b + j) & 255);
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send_beat(d, (off + 4 >= lens[p]), (off + 4 >= lens[p]) ? 2'(4 - n) : 2'd0);
            b += n;
          end
        end
      end
      begin : ready_driver
        while (!rx_done) begin
          o_rdy = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
      begin : receiver
        int b;
        b = 0;
        for (int p = 0; p < 50 && !rx_done; p++) begin
          int rem;
          rem = lens[p];
          while (rem > 0 && !rx_done) begin
            logic [23:0] d; logic e; logic [1:0] m; bit ok; bit good;
            int n;
            logic       exp_e;
            logic [1:0] exp_m;
            n     = (rem < 3) ? rem : 3;
            exp_e = (rem <= 3);
            exp_m = exp_e ? 2'(3 - n) : 2'd0;
            recv_beat(d, e, m, ok);
            good = ok && (e === exp_e) && (m === exp_m);
            for (int j = 0; j < n; j++)
              if (d[j*8 +: 8] !== 8'((b + j) & 255)) good = 1'b0;
            check_cnt++;
            if (!good) begin
              $display("FAIL random_pkt%0d: got ok=%b dat=%h eop=%b mty=%0d, want first byte %h n=%0d eop=%b mty=%0d",
                       p, ok, d, e, m, 8'(b & 255), n, exp_e, exp_m);
              if (!ok) rx_done = 1'b1;
            end else pass_cnt++;
            b   += n;
            rem -= n;
          end
        end
        rx_done = 1'b1;
      end
    join
    o_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    o_rdy = 1'b0;
    send_beat(32'h18171615, 1'b0, 2'd0);
    o_rdy = 1'b1;
    @(posedge clk);
    #1;
    o_rdy = 1'b0;
    send_beat(32'h1C1B1A19, 1'b1, 2'd0);
    @(negedge clk);
    check_cnt++;
    if (o_val !== 1'b1 || o_eop !== 1'b0 || i_rdy !== 1'b0 || o_dat !== 24'h1A1918)
      $display("FAIL midrst_pre: got val=%b eop=%b rdy=%b dat=%h, want 1 0 0 1a1918", o_val, o_eop, i_rdy, o_dat);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (o_val !== 1'b0 || o_eop !== 1'b0 || o_mty !== 2'd0 || i_rdy !== 1'b0)
      $display("FAIL midrst_async: got val=%b eop=%b mty=%0d rdy=%b, want 0 0 0 0", o_val, o_eop, o_mty, i_rdy);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (o_val !== 1'b0 || i_rdy !== 1'b1)
      $display("FAIL midrst_release: got o_val=%b i_rdy=%b, want 0 1", o_val, i_rdy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    o_rdy = 1'b1;
    fork
      begin
        send_beat(32'h04030201, 1'b0, 2'd0);
        send_beat(32'h00000605, 1'b1, 2'd2);
      end
      begin
        logic [23:0] d; logic e; logic [1:0] m; bit ok;
        recv_beat(d, e, m, ok);
        check_cnt++;
        if (!ok || d !== 24'h030201 || e !== 1'b0)
          $display("FAIL midrst_beat0: got ok=%b dat=%h eop=%b, want 030201 0", ok, d, e);
        else pass_cnt++;
        recv_beat(d, e, m, ok);
        check_cnt++;
        if (!ok || d !== 24'h060504 || e !== 1'b1 || m !== 2'd0)
          $display("FAIL midrst_beat1: got ok=%b dat=%h eop=%b mty=%0d, want 060504 1 0", ok, d, e, m);
        else pass_cnt++;
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps_width_gearbox.md
PS_WIDTH_GEARBOX -- requirements
Module: ps_width_gearbox

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per data word.
REQ-002 SHALL have parameter IWORDS, default 4: words per input beat (>=1).
REQ-003 SHALL have parameter OWORDS, default 3: words per output beat (>=1).
REQ-004 SHALL define IMW = (IWORDS>1 ? $clog2(IWORDS) : 1) and OMW = (OWORDS>1 ? $clog2(OWORDS) : 1).
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clk  in  1  single clock; all state on its rising edge.
REQ-007 i_dat  in  IWORDS*WIDTH  input words; earliest word in bits [WIDTH-1:0].
REQ-008 i_mty  in  IMW  count of empty words at the MS end; meaningful only with i_eop, else treated as 0.
REQ-009 i_val / i_eop  in  1 each  input beat valid / last beat of packet.
REQ-010 i_rdy  out  1  input ready.
REQ-011 o_dat  out  OWORDS*WIDTH  output words; earliest word in bits [WIDTH-1:0].
REQ-012 o_mty  out  OMW  empty words at the MS end of an o_eop beat; 0 otherwise.
REQ-013 o_val / o_eop  out  1 each  output valid / last beat of packet.
REQ-014 o_rdy  in  1  output ready.

Function
REQ-015 SHALL transfer a beat on any edge where val & rdy; packets SHALL pass in order, word-exact, and never merge or split.
REQ-016 SHALL hold a word buffer of B = IWORDS+OWORDS words, a count c (0..B), and a flag eop_pend.
REQ-017 i_rdy SHALL be !reset & !eop_pend & (c <= OWORDS); there SHALL be no combinational path from o_rdy or i_val to i_rdy.
REQ-018 An accepted beat SHALL append IWORDS - (i_eop ? i_mty : 0) words after the c held words and set eop_pend if i_eop.
REQ-019 o_val SHALL be (c >= OWORDS) | (eop_pend & c > 0).
REQ-020 o_eop SHALL be eop_pend & (c <= OWORDS); o_mty SHALL then be OWORDS - c, else 0.
REQ-021 An output handshake SHALL remove min(c, OWORDS) words from the buffer head; a pop and a push on one edge SHALL both apply (push lands after the remaining words).
REQ-022 The o_eop handshake SHALL clear eop_pend; the next packet is accepted no earlier than the following edge.
REQ-023 While o_val & !o_rdy, o_dat/o_mty/o_eop SHALL stay stable.
REQ-024 Latency SHALL be one cycle: words accepted on edge N are visible on o_dat after edge N.
REQ-025 Output word slots beyond OWORDS - o_mty SHALL be don't-care.
REQ-026 Input with i_mty >= IWORDS is illegal; behaviour is unspecified.

Reset
REQ-027 Reset assertion SHALL asynchronously set c=0, eop_pend=0, hence o_val=0, o_eop=0, o_mty=0, i_rdy=0.
REQ-028 i_rdy SHALL be 1 from the first cycle after reset deasserts; o_dat content after reset is don't-care.
REQ-029 Reset mid-packet SHALL discard all buffered words; no residual word SHALL appear in the next packet.

Verification (WIDTH=8, IWORDS=4, OWORDS=3)
REQ-030 Reset held 3 cycles -> o_val=0, o_eop=0, i_rdy=0 throughout; i_rdy=1 the cycle after release.
REQ-031 Beats {1,2,3,4}, {5,6,7,8 eop mty=0}, o_rdy=1 -> outputs {1,2,3}, {4,5,6}, {7,8,x eop mty=1}.
REQ-032 Single beat {9,10,x,x} eop mty=2 -> one output {9,10,x} eop mty=1 the cycle after acceptance; i_rdy=0 until it is taken.
REQ-033 o_rdy=0 for 5 cycles mid-packet -> o_dat/o_mty/o_eop unchanged, i_rdy=0 while c>3, no word lost or duplicated.
REQ-034 Random i_val and o_rdy each cycle, 50 packets of random length 1..20 bytes numbered sequentially -> output byte sequence and eop positions match input; o_mty consistent with packet length mod 3.
REQ-035 Reset asserted with c=5 and eop_pend=1 -> outputs drop to 0 immediately; next packet {1..6} converts to {1,2,3}, {4,5,6 eop mty=0}.
